snd_arbiter: RTL and testbench
==============================

# snd_arbiter

Schedules sound requests from several game-logic sources onto the single sound manager (`sndm`), which owns the piezo. The block latches per-source requests and picks a winner by fixed priority. It drives `snd_mode` and a stretched `trig` pulse into `sndm`, then tracks `sndm`'s `playing` output until the sound ends. Optionally, a higher-priority request restarts (preempts) the current sound. It sits between the game FSM / hit detector / timer logic and `sndm`, all on `clk_1mhz`.

## Interface
- `NREQ`, 4: number of requesters; index 0 has the highest priority.
- `TRIG_CYCLES`, 4: cycles `trig` is held high per launch; must be ≥3.
- `START_TIMEOUT`, 16: maximum cycles to wait for `playing` after the launch.
- `GAP_CYCLES`, 20000: silent gap after each sound (20 ms); must be ≥2.
- `PREEMPT`, 1: 1 lets higher-priority requests restart a playing sound.

- `clk_1mhz`  in  1  system clock, 1 MHz.
- `rst`  in  1  reset, asynchronous, active-high.
- `req`  in  NREQ  request strobes; every cycle high counts as one request.
- `req_mode`  in  3*NREQ  sound code for requester i, in bits [3i+2:3i].
- `playing`  in  1  from `sndm`.
- `snd_mode`  out  3  to `sndm`.
- `trig`  out  1  to `sndm`.
- `busy`  out  1  high when the state is not IDLE.
- `grant`  out  NREQ  one-hot, single-cycle pulse when a request is launched.
- `cur_src`  out  $clog2(NREQ)  index of the last granted source.
- `err`  out  1  single-cycle pulse on start timeout.

## Operation
- **Capture:**
  - A request on `req[i]` with a nonzero `req_mode` sets `pend[i]` and stores `pmode[i]`.
  - Mode 3'b000 is ignored.
  - A new request on a source that is already pending overwrites its mode (latest wins).
  - A capture in the same cycle that the pending flag is cleared by a grant wins, so the flag stays set with the new mode.
- **Select:** the lowest pending index wins.
- **States:** IDLE, HOLD, WAIT_START, PLAY, SETTLE, GAP.
- **IDLE:** if any `pend` bit is set:
  - `snd_mode` ← `pmode[w]`, `cur_src` ← w.
  - Clear `pend[w]` and pulse `grant[w]`.
  - Set `trig`=1 and go to HOLD.
- **HOLD:** `trig`=1 for `TRIG_CYCLES` cycles counted from the grant cycle, then `trig`=0 and go to WAIT_START.
- **WAIT_START:**
  - If `playing`=1, go to PLAY.
  - If the wait reaches `START_TIMEOUT` cycles, pulse `err` and go to GAP.
- **PLAY:**
  - If `playing`=0, go to GAP.
  - Otherwise, if `PREEMPT`=1 and any `pend[j]` with j < `cur_src` is set, go to SETTLE.
  - Equal or lower priority requests wait in their pending latch.
- **SETTLE:** `trig`=0 for 2 cycles so `sndm`'s 2-FF synchronizer sees a low level. Then perform the IDLE launch actions directly; this does not pass through IDLE.
  - On a preempted launch, `playing` may stay high continuously. WAIT_START accepts this, because `sndm` restarts on the new edge.
- **GAP:** `trig`=0 for `GAP_CYCLES` cycles, then go to IDLE. No preemption during GAP.
- **Outputs:**
  - `snd_mode` holds its value after a sound ends and changes only at a launch.
  - `busy` = (state ≠ IDLE).

## Timing
- **Reset:** state IDLE; `pend`=0; `snd_mode`=0, `trig`=0, `busy`=0, `grant`=0, `cur_src`=0, `err`=0.
- **Reset mid-operation:** `trig` drops asynchronously and all pending requests are lost. `sndm` shares `rst`, so it also stops.
- **Launch latency:** a request at cycle t is captured at edge t+1 and granted, with `trig` high, at edge t+2 when the block is IDLE.
- **Trigger width:** `trig` is high exactly `TRIG_CYCLES` cycles per launch. Between launches it is low for at least 2 cycles, guaranteed by GAP or SETTLE.
- **End of sound:** GAP is entered one cycle after `playing` falls. IDLE is entered `GAP_CYCLES` cycles later.
- **Timing source:** all counters are sized by `$clog2` of their parameter; none wraps, since each resets on state entry.

## Structure
- **Shared package `snd_pkg`:**
  - Sound codes: BEEP=1, START=2, HIT=3, MISS=4, WIN=5, GAMEOVER=6, GAMECLEAR=7, NONE=0.
  - Arbiter state enum.
  - The codes are reused by `sndm` callers.
- **Sub-module `snd_prio_enc`:** parameterized fixed-priority encoder returning valid plus the lowest set index. It is used for launch selection and for the preempt compare.

## Test plan
- **Single request, idle:** `req[2]` high for 1 cycle, mode 3, idle → `grant`=4'b0100 at t+2, `trig` high for 4 cycles, `snd_mode`=3. With a model `playing` of 200 cycles, `busy` falls `GAP_CYCLES`+1 cycles after `playing` falls.
- **Simultaneous requests:** `req`=4'b1010 in the same cycle → source 1 is granted first; source 3 is granted after the first sound and its gap end.
- **Preemption:** during PLAY of source 3, `req[0]` mode 6 → `trig` low for 2 cycles, then high 4 cycles with `snd_mode`=6 and `grant`=4'b0001. With `PREEMPT`=0 → no retrigger; source 0 is launched after the gap.
- **Overwrite:** `req[1]` mode 4 then mode 5 while busy → one launch only, with `snd_mode`=5. A mode-0 request leaves `pend` unchanged.
- **Start timeout:** `playing` tied 0 → `err` pulses at cycle 16 of WAIT_START; GAP follows, then the next pending request is launched.
- **Reset mid-HOLD:** `rst` asserted during HOLD → `trig` goes 0 immediately, all outputs take reset values, and no grant follows after reset.

Source files
------------

// File: rtl/snd_pkg.sv
// Shared sound codes and arbiter state encoding.
// Sound codes are also used by sndm callers.
package snd_pkg;

  typedef enum logic [2:0] {
    SND_NONE      = 3'd0,
    SND_BEEP      = 3'd1,
    SND_START     = 3'd2,
    SND_HIT       = 3'd3,
    SND_MISS      = 3'd4,
    SND_WIN       = 3'd5,
    SND_GAMEOVER  = 3'd6,
    SND_GAMECLEAR = 3'd7
  } snd_code_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_WAIT_START,
    ST_PLAY,
    ST_SETTLE,
    ST_GAP
  } arb_state_e;

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/snd_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
// Used for launch selection and the preempt compare.
module snd_prio_enc #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] in_vec,
  output logic         valid,
  output logic [W-1:0] idx
);

  always_comb begin
    valid = |in_vec;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (in_vec[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/snd_arbiter.sv
// Sound request arbiter in front of sndm: latches requests,
// launches by fixed priority, stretches trig, tracks playing.
module snd_arbiter
  import snd_pkg::*;
#(
  parameter int NREQ          = 4,
  parameter int TRIG_CYCLES   = 4,
  parameter int START_TIMEOUT = 16,
  parameter int GAP_CYCLES    = 20000,
  parameter bit PREEMPT       = 1'b1
) (
  input  logic                    clk_1mhz,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [3*NREQ-1:0]       req_mode,
  input  logic                    playing,
  output logic [2:0]              snd_mode,
  output logic                    trig,
  output logic                    busy,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] cur_src,
  output logic                    err
);

  localparam int SW = $clog2(NREQ);
  localparam int CW = $clog2(
    max3(TRIG_CYCLES, START_TIMEOUT, GAP_CYCLES) + 1);

  arb_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0] pend_q, pend_d;
  logic [NREQ-1:0][2:0] pmode_q, pmode_d;
  logic [2:0] snd_mode_q, snd_mode_d;
  logic trig_q, trig_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [SW-1:0] cur_src_q, cur_src_d;
  logic err_q, err_d;
  logic win_vld;
  logic [SW-1:0] win_idx;
  logic launch;

  snd_prio_enc #(
    .N(NREQ),
    .W(SW)
  ) u_enc (
    .in_vec(pend_q),
    .valid (win_vld),
    .idx   (win_idx)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CW'(1);
    trig_d     = 1'b0;
    grant_d    = '0;
    err_d      = 1'b0;
    snd_mode_d = snd_mode_q;
    cur_src_d  = cur_src_q;
    launch     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        launch = win_vld;
      end
      ST_HOLD: begin
        trig_d = 1'b1;
        if (cnt_q == CW'(TRIG_CYCLES - 1)) begin
          trig_d  = 1'b0;
          state_d = ST_WAIT_START;
          cnt_d   = '0;
        end
      end
      ST_WAIT_START: begin
        if (playing) begin
          state_d = ST_PLAY;
          cnt_d   = '0;
        end else if (cnt_q == CW'(START_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_GAP;
          cnt_d   = '0;
        end
      end
      ST_PLAY: begin
        cnt_d = '0;
        if (!playing) begin
          state_d = ST_GAP;
        end else if (PREEMPT && win_vld
                     && (win_idx < cur_src_q)) begin
          state_d = ST_SETTLE;
        end
      end
      // two low cycles let sndm's synchronizer see a fresh edge
      ST_SETTLE: begin
        launch = (cnt_q == CW'(1));
      end
      ST_GAP: begin
        if (cnt_q == CW'(GAP_CYCLES - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (launch) begin
      state_d          = ST_HOLD;
      cnt_d            = '0;
      trig_d           = 1'b1;
      grant_d[win_idx] = 1'b1;
      snd_mode_d       = pmode_q[win_idx];
      cur_src_d        = win_idx;
    end
  end

  // a capture in the grant cycle wins over the clear
  always_comb begin
    pend_d  = pend_q;
    pmode_d = pmode_q;
    if (launch) pend_d[win_idx] = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && (req_mode[3*i +: 3] != 3'd0)) begin
        pend_d[i]  = 1'b1;
        pmode_d[i] = req_mode[3*i +: 3];
      end
    end
  end

  always_ff @(posedge clk_1mhz or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      pend_q     <= '0;
      pmode_q    <= '0;
      snd_mode_q <= '0;
      trig_q     <= 1'b0;
      grant_q    <= '0;
      cur_src_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      pmode_q    <= pmode_d;
      snd_mode_q <= snd_mode_d;
      trig_q     <= trig_d;
      grant_q    <= grant_d;
      cur_src_q  <= cur_src_d;
      err_q      <= err_d;
    end
  end

  assign snd_mode = snd_mode_q;
  assign trig     = trig_q;
  assign busy     = (state_q != ST_IDLE);
  assign grant    = grant_q;
  assign cur_src  = cur_src_q;
  assign err      = err_q;

endmodule

// File: tb/tb_snd_arbiter.sv
// Directed bench for snd_arbiter: vector table plus
// hand sequences for priority, preemption, timeout, reset.
module tb_snd_arbiter;

  logic clk_1mhz = 1'b0;
  logic rst;
  logic [3:0] req;
  logic [11:0] req_mode;
  logic playing;
  logic [2:0] snd_mode, np_snd_mode;
  logic trig, np_trig;
  logic busy, np_busy;
  logic [3:0] grant, np_grant;
  logic [1:0] cur_src, np_cur_src;
  logic err, np_err;

  int total = 0;
  int bad = 0;

  always #5 clk_1mhz = ~clk_1mhz;

  snd_arbiter #(
    .NREQ(4), .TRIG_CYCLES(4), .START_TIMEOUT(16),
    .GAP_CYCLES(20), .PREEMPT(1'b1)
  ) u_dut (
    .clk_1mhz(clk_1mhz), .rst(rst), .req(req),
    .req_mode(req_mode), .playing(playing),
    .snd_mode(snd_mode), .trig(trig), .busy(busy),
    .grant(grant), .cur_src(cur_src), .err(err)
  );

  snd_arbiter #(
    .NREQ(4), .TRIG_CYCLES(4), .START_TIMEOUT(16),
    .GAP_CYCLES(20), .PREEMPT(1'b0)
  ) u_np (
    .clk_1mhz(clk_1mhz), .rst(rst), .req(req),
    .req_mode(req_mode), .playing(playing),
    .snd_mode(np_snd_mode), .trig(np_trig),
    .busy(np_busy), .grant(np_grant),
    .cur_src(np_cur_src), .err(np_err)
  );

  typedef struct {
    logic [3:0]  req;
    logic [11:0] mode;
    logic        play;
    logic [3:0]  grant;
    logic        trig;
    logic        busy;
    logic [2:0]  smode;
    logic        err;
  } vec_t;

  vec_t tv[8];

  task automatic tick();
    @(posedge clk_1mhz);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  int n, k;
  int err_n, err_at, gr_n, gr_at;
  logic [3:0] gr_val;
  logic [2:0] gr_mode;

  initial begin
    // req[2] mode 3 single request, then into PLAY
    tv[0] = '{4'b0000, 12'h000, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0};
    tv[1] = '{4'b0100, 12'h0C0, 1'b0, 4'b0000, 1'b0, 1'b0, 3'd0, 1'b0};
    tv[2] = '{4'b0000, 12'h000, 1'b0, 4'b0100, 1'b1, 1'b1, 3'd3, 1'b0};
    tv[3] = '{4'b0000, 12'h000, 1'b0, 4'b0000, 1'b1, 1'b1, 3'd3, 1'b0};
    tv[4] = '{4'b0000, 12'h000, 1'b0, 4'b0000, 1'b1, 1'b1, 3'd3, 1'b0};
    tv[5] = '{4'b0000, 12'h000, 1'b0, 4'b0000, 1'b1, 1'b1, 3'd3, 1'b0};
    tv[6] = '{4'b0000, 12'h000, 1'b0, 4'b0000, 1'b0, 1'b1, 3'd3, 1'b0};
    tv[7] = '{4'b0000, 12'h000, 1'b1, 4'b0000, 1'b0, 1'b1, 3'd3, 1'b0};

    rst = 1'b1;
    req = '0;
    req_mode = '0;
    playing = 1'b0;
    tick();
    tick();
    chk("rst_trig", 32'(trig), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_mode", 32'(snd_mode), 32'd0);
    chk("rst_src", 32'(cur_src), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      req = tv[i].req;
      req_mode = tv[i].mode;
      playing = tv[i].play;
      tick();
      chk($sformatf("v%0d_grant", i), 32'(grant), 32'(tv[i].grant));
      chk($sformatf("v%0d_trig", i), 32'(trig), 32'(tv[i].trig));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tv[i].busy));
      chk($sformatf("v%0d_mode", i), 32'(snd_mode), 32'(tv[i].smode));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(tv[i].err));
    end
    req = '0;
    req_mode = '0;

    // 200-cycle sound, then busy falls GAP+1 later
    repeat (199) tick();
    chk("a_play_busy", 32'(busy), 32'd1);
    playing = 1'b0;
    n = 0;
    do begin tick(); n++; end while (busy && n < 200);
    chk("a_idle_lat", 32'(n), 32'd21);
    chk("a_mode_held", 32'(snd_mode), 32'd3);

    // simultaneous req[1] (mode 2) and req[3] (mode 5)
    req = 4'b1010;
    req_mode = 12'hA10;
    tick();
    req = '0;
    req_mode = '0;
    tick();
    chk("b_grant1", 32'(grant), 32'b0010);
    chk("b_mode1", 32'(snd_mode), 32'd2);
    repeat (4) tick();
    playing = 1'b1;
    repeat (10) tick();
    playing = 1'b0;
    n = 0;
    do begin tick(); n++; end while (grant == 0 && n < 100);
    chk("b_grant3_lat", 32'(n), 32'd22);
    chk("b_grant3", 32'(grant), 32'b1000);
    chk("b_mode3", 32'(snd_mode), 32'd5);
    chk("b_src3", 32'(cur_src), 32'd3);

    // preempt source 3 by req[0] mode 6
    repeat (4) tick();
    playing = 1'b1;
    repeat (3) tick();
    req = 4'b0001;
    req_mode = 12'h006;
    tick();
    req = '0;
    req_mode = '0;
    chk("c_cap_trig", 32'(trig), 32'd0);
    tick();
    chk("c_settle1_trig", 32'(trig), 32'd0);
    chk("c_settle1_busy", 32'(busy), 32'd1);
    tick();
    chk("c_settle2_trig", 32'(trig), 32'd0);
    tick();
    chk("c_pre_grant", 32'(grant), 32'b0001);
    chk("c_pre_trig", 32'(trig), 32'd1);
    chk("c_pre_mode", 32'(snd_mode), 32'd6);
    chk("c_pre_src", 32'(cur_src), 32'd0);
    chk("c_np_grant", 32'(np_grant), 32'd0);
    chk("c_np_trig", 32'(np_trig), 32'd0);
    chk("c_np_mode", 32'(np_snd_mode), 32'd5);
    n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (trig) n++;
    end
    tick();
    chk("c_trig_width", 32'(n), 32'd4);
    chk("c_trig_end", 32'(trig), 32'd0);
    tick();
    playing = 1'b0;
    n = 0;
    do begin tick(); n++; end while (np_grant == 0 && n < 100);
    chk("c_np_lat", 32'(n), 32'd22);
    chk("c_np_grant0", 32'(np_grant), 32'b0001);
    chk("c_np_mode6", 32'(np_snd_mode), 32'd6);
    chk("c_main_idle", 32'(busy), 32'd0);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // overwrite while busy, then start timeout
    req = 4'b0100;
    req_mode = 12'h040;
    tick();
    req = '0;
    req_mode = '0;
    tick();
    chk("d_grant2", 32'(grant), 32'b0100);
    req = 4'b0010;
    req_mode = 12'h020;
    tick();
    req_mode = 12'h028;
    tick();
    req_mode = 12'h000;
    tick();
    req = '0;
    err_n = 0; err_at = 0; gr_n = 0; gr_at = 0;
    gr_val = '0; gr_mode = '0;
    for (k = 4; k <= 60; k++) begin
      tick();
      if (err) begin err_n++; err_at = k; end
      if (grant != 0) begin
        gr_n++; gr_at = k;
        gr_val = grant; gr_mode = snd_mode;
      end
    end
    chk("e_err_count", 32'(err_n), 32'd1);
    chk("e_err_at", 32'(err_at), 32'd20);
    chk("d_launch_count", 32'(gr_n), 32'd1);
    chk("d_launch_at", 32'(gr_at), 32'd41);
    chk("d_grant1", 32'(gr_val), 32'b0010);
    chk("d_mode5", 32'(gr_mode), 32'd5);
    gr_n = 0;
    n = 0;
    do begin
      tick(); n++;
      if (grant != 0) gr_n++;
    end while (busy && n < 100);
    chk("d_no_more", 32'(gr_n), 32'd0);
    chk("d_idle", 32'(busy), 32'd0);

    // reset during HOLD with another request pending
    req = 4'b1000;
    req_mode = 12'hE00;
    tick();
    req = '0;
    req_mode = '0;
    tick();
    chk("f_grant3", 32'(grant), 32'b1000);
    req = 4'b0100;
    req_mode = 12'h080;
    tick();
    req = '0;
    req_mode = '0;
    chk("f_hold_trig", 32'(trig), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("f_async_trig", 32'(trig), 32'd0);
    chk("f_busy", 32'(busy), 32'd0);
    chk("f_mode", 32'(snd_mode), 32'd0);
    chk("f_src", 32'(cur_src), 32'd0);
    tick();
    rst = 1'b0;
    gr_n = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (grant != 0 || trig) gr_n++;
    end
    chk("f_no_grant", 32'(gr_n), 32'd0);
    chk("f_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
